ahb_lite_arb2: RTL and testbench
================================

AHB_LITE_ARB2 -- requirements
Module: ahb_lite_arb2

Interface
REQ-001 SHALL have parameter AW, default 32, address width.
REQ-002 SHALL have parameter DW, default 32, data width.
REQ-003 CLK  in  1  the single clock; all state changes on its rising edge.
REQ-004 RST  in  1  reset, asynchronous and active-high.
REQ-005 HADDR_I/HADDR_D  in  AW  instruction/data master address.
REQ-006 HTRANS_I/HTRANS_D  in  2  master transfer type; only IDLE (00) and NONSEQ (10) are used.
REQ-007 HSIZE_I/HSIZE_D  in  3  master transfer size.
REQ-008 HWRITE_I/HWRITE_D  in  1  master write.
REQ-009 HWDATA_I/HWDATA_D  in  DW  master write data, data phase.
REQ-010 HRDATA_I/HRDATA_D  out  DW  read data returned to each master.
REQ-011 HREADY_I/HREADY_D  out  1  per-master ready.
REQ-012 HRESP_I/HRESP_D  out  1  per-master response.
REQ-013 HADDR_S, HTRANS_S, HSIZE_S, HWRITE_S, HWDATA_S  out  AW/2/3/1/DW  shared slave port.
REQ-014 HRDATA_S, HREADY_S, HRESP_S  in  DW/1/1  shared slave return.

Function
- REQ-015 SHALL share one AHB-Lite slave between master I and master D, with no more than one slave address phase per cycle.
- REQ-016 Each master SHALL have a one-entry pending buffer (addr, size, write) loaded when that master presents NONSEQ with its HREADY high and is not granted the slave address phase that cycle.
- REQ-017 A master with a full pending buffer SHALL see its HREADY low until its buffered transfer finishes its slave data phase.
- REQ-018 Data-phase FSM states: IDLE, DPH_I, DPH_D.
  - Enter DPH_x in the cycle after master x wins an address phase with HREADY_S high.
  - Leave DPH_x on HREADY_S high: go to DPH_y if an address phase was granted that cycle, else go to IDLE.
- REQ-019 In DPH_x, HWDATA_S SHALL equal HWDATA_x.
- REQ-020 In DPH_x, HRDATA_x, HRESP_x and HREADY_x SHALL follow the slave.
- REQ-021 The non-owning master SHALL see HREADY low only if its pending buffer is full; otherwise it sees HREADY high.
- REQ-022 Grant candidates: a pending buffer entry, else a live NONSEQ.
  - A pending entry SHALL be issued before that master's new requests.
- REQ-023 With both masters requesting in one cycle, default arbitration SHALL be fixed priority D over I.
- REQ-024 HTRANS_S SHALL be IDLE when no master is granted; HADDR_S then holds its last value.
- REQ-025 An ERROR response (HRESP_S high, two-cycle) SHALL be forwarded only to the data-phase owner, with HREADY_x low then high, aligned to the slave.
- REQ-026 After an ERROR, the errored master's pending buffer SHALL NOT be affected.
- REQ-027 Zero-wait slave with alternating requests SHALL sustain one transfer per cycle.
- REQ-028 Added latency for a loser SHALL be exactly one cycle per transfer ahead of it.

Reset
- REQ-029 While RST is high:
  - FSM = IDLE; both pending buffers empty; round-robin pointer = I.
  - HTRANS_S = IDLE; HADDR_S = 0; HSIZE_S = 0; HWRITE_S = 0; HWDATA_S = 0.
  - HREADY_I = HREADY_D = 1; HRESP_I = HRESP_D = 0; HRDATA_I = HRDATA_D = 0.
- REQ-030 RST asserted mid-transfer SHALL abandon all buffered requests, with no replay after release.

Configuration
- REQ-031 With macro URV_ARB_ROUND_ROBIN_EN defined, simultaneous requests SHALL alternate.
  - The master not granted last wins.
  - The pointer updates only on a grant.
- REQ-032 Without URV_ARB_ROUND_ROBIN_EN, fixed D-over-I priority per REQ-023 SHALL apply, and no pointer register exists.

Structure
- REQ-033 Package urv_ahb_pkg SHALL hold the HTRANS encodings (IDLE, NONSEQ) and the FSM state enum.
- REQ-034 The FSM and grant logic SHALL live in ahb_lite_arb2.
- REQ-035 The per-master pending buffer SHALL be one sub-module, ahb_req_buf, instantiated twice.

Verification
- REQ-036 Lone I read of 0x100, zero-wait slave: HTRANS_S = NONSEQ same cycle; HRDATA_I valid next cycle; HREADY_D stays 1.
- REQ-037 I and D both NONSEQ in the same cycle, fixed priority: D issued in cycle n, I from its buffer in n+1; HREADY_I low for one cycle.
- REQ-038 Same stimulus with URV_ARB_ROUND_ROBIN_EN, repeated 4 times: grants alternate D, I, I, D...; no master is starved.
- REQ-039 Slave inserts 2 wait states on a D write of 0xDEADBEEF to 0x200: HWDATA_S is stable for 3 cycles; a queued I request waits, then issues as D's data phase completes.
- REQ-040 Slave returns ERROR on an I fetch: HRESP_I is high for 2 cycles, with HREADY_I low then high; a D transfer in flight is unaffected.
- REQ-041 RST pulse while D's pending buffer is full: after release, HTRANS_S = IDLE, both HREADY = 1, and no replayed transfer occurs.

Source files
------------

// File: rtl/urv_ahb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : urv_ahb_pkg                                               |
// | Purpose  : Shared AHB-Lite encodings and the data-phase FSM state    |
// |            type for the two-master arbiter.                          |
// | Ports    : none (package)                                            |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package urv_ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   // Which master currently owns the slave data phase
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DPH_I = 2'd1,
      ST_DPH_D = 2'd2
   } dph_state_t;

endpackage
`default_nettype wire

// File: rtl/ahb_req_buf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ahb_req_buf                                               |
// | Purpose  : One-entry holding buffer for an address phase that was    |
// |            accepted from a master but lost arbitration.              |
// | Ports    : clk, rst (async, active-high)                             |
// |            load      - capture req_addr/req_size/req_write           |
// |            clear     - entry issued to the slave, drop it            |
// |            valid     - entry is full                                 |
// |            addr/size/write - buffered address-phase controls         |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module ahb_req_buf #(
   parameter int AW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic          clear,
   input  logic [AW-1:0] req_addr,
   input  logic [2:0]    req_size,
   input  logic          req_write,
   output logic          valid,
   output logic [AW-1:0] addr,
   output logic [2:0]    size,
   output logic          write
);

   logic          r_valid;
   logic [AW-1:0] r_addr;
   logic [2:0]    r_size;
   logic          r_write;

   // clear and load never coincide: a master can only be accepted
   // while its buffer is empty.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_addr  <= '0;
         r_size  <= '0;
         r_write <= 1'b0;
      end else if (clear) begin
         r_valid <= 1'b0;
      end else if (load) begin
         r_valid <= 1'b1;
         r_addr  <= req_addr;
         r_size  <= req_size;
         r_write <= req_write;
      end
   end

   assign valid = r_valid;
   assign addr  = r_addr;
   assign size  = r_size;
   assign write = r_write;

endmodule
`default_nettype wire

// File: rtl/ahb_lite_arb2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ahb_lite_arb2                                             |
// | Purpose  : Shares one AHB-Lite slave between an instruction master   |
// |            (I) and a data master (D). A master that loses the        |
// |            address phase is parked in its ahb_req_buf and stalled    |
// |            until that transfer completes its data phase.             |
// | Ports    : clk, rst (async, active-high)                             |
// |            haddr/htrans/hsize/hwrite/hwdata_{i,d}  master requests   |
// |            hrdata/hready/hresp_{i,d}               master returns    |
// |            haddr/htrans/hsize/hwrite/hwdata_s      slave request     |
// |            hrdata/hready/hresp_s                   slave return      |
// | Config   : URV_ARB_ROUND_ROBIN_EN - alternate winners on contention; |
// |            undefined gives fixed D-over-I priority.                  |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module ahb_lite_arb2
   import urv_ahb_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] haddr_i,
   input  logic [1:0]    htrans_i,
   input  logic [2:0]    hsize_i,
   input  logic          hwrite_i,
   input  logic [DW-1:0] hwdata_i,
   output logic [DW-1:0] hrdata_i,
   output logic          hready_i,
   output logic          hresp_i,
   input  logic [AW-1:0] haddr_d,
   input  logic [1:0]    htrans_d,
   input  logic [2:0]    hsize_d,
   input  logic          hwrite_d,
   input  logic [DW-1:0] hwdata_d,
   output logic [DW-1:0] hrdata_d,
   output logic          hready_d,
   output logic          hresp_d,
   output logic [AW-1:0] haddr_s,
   output logic [1:0]    htrans_s,
   output logic [2:0]    hsize_s,
   output logic          hwrite_s,
   output logic [DW-1:0] hwdata_s,
   input  logic [DW-1:0] hrdata_s,
   input  logic          hready_s,
   input  logic          hresp_s
);

   dph_state_t    r_state, w_state_nxt;

   logic          w_pend_i, w_pend_d;
   logic [AW-1:0] w_paddr_i, w_paddr_d;
   logic [2:0]    w_psize_i, w_psize_d;
   logic          w_pwrite_i, w_pwrite_d;

   logic          w_hready_i, w_hready_d;
   logic          w_live_i, w_live_d;
   logic          w_cand_i, w_cand_d;
   logic          w_sel_i, w_sel_d;
   logic          w_gnt_i, w_gnt_d;
   logic          w_pri_d;

   logic [AW-1:0] r_haddr_hold;
   logic [2:0]    r_hsize_hold;
   logic          r_hwrite_hold;

   // Master-side ready: the data-phase owner tracks the slave, the
   // other master is stalled only while it has a parked request.
   assign w_hready_i = (r_state == ST_DPH_I) ? hready_s : !w_pend_i;
   assign w_hready_d = (r_state == ST_DPH_D) ? hready_s : !w_pend_d;
   assign hready_i   = w_hready_i;
   assign hready_d   = w_hready_d;

   // A live request is one the master is handing over this cycle.
   assign w_live_i = !rst && (htrans_i == HTRANS_NONSEQ) && w_hready_i;
   assign w_live_d = !rst && (htrans_d == HTRANS_NONSEQ) && w_hready_d;

   // Buffered entry takes precedence; live and buffered are exclusive
   // because a full buffer forces the master's ready low.
   assign w_cand_i = w_pend_i || w_live_i;
   assign w_cand_d = w_pend_d || w_live_d;

`ifdef URV_ARB_ROUND_ROBIN_EN
   // Remembers the winner of the last contested grant (1 = D).
   // Reset value points at I so D wins the first contest.
   logic r_rr_last_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rr_last_d <= 1'b0;
      end else if (w_cand_i && w_cand_d && hready_s) begin
         r_rr_last_d <= w_sel_d;
      end
   end

   assign w_pri_d = !r_rr_last_d;
`else
   assign w_pri_d = 1'b1;
`endif

   assign w_sel_d = w_cand_d && (!w_cand_i || w_pri_d);
   assign w_sel_i = w_cand_i && !w_sel_d;
   assign w_gnt_d = w_sel_d && hready_s;
   assign w_gnt_i = w_sel_i && hready_s;

   ahb_req_buf #(.AW(AW)) u_buf_i (
      .clk       (clk),
      .rst       (rst),
      .load      (w_live_i && !w_gnt_i),
      .clear     (w_gnt_i && w_pend_i),
      .req_addr  (haddr_i),
      .req_size  (hsize_i),
      .req_write (hwrite_i),
      .valid     (w_pend_i),
      .addr      (w_paddr_i),
      .size      (w_psize_i),
      .write     (w_pwrite_i)
   );

   ahb_req_buf #(.AW(AW)) u_buf_d (
      .clk       (clk),
      .rst       (rst),
      .load      (w_live_d && !w_gnt_d),
      .clear     (w_gnt_d && w_pend_d),
      .req_addr  (haddr_d),
      .req_size  (hsize_d),
      .req_write (hwrite_d),
      .valid     (w_pend_d),
      .addr      (w_paddr_d),
      .size      (w_psize_d),
      .write     (w_pwrite_d)
   );

   // Slave address phase. The selected request is presented even while
   // the slave is stalled; it only counts as granted with hready_s high.
   always_comb begin
      htrans_s = HTRANS_IDLE;
      haddr_s  = r_haddr_hold;
      hsize_s  = r_hsize_hold;
      hwrite_s = r_hwrite_hold;
      if (w_sel_d) begin
         htrans_s = HTRANS_NONSEQ;
         haddr_s  = w_pend_d ? w_paddr_d  : haddr_d;
         hsize_s  = w_pend_d ? w_psize_d  : hsize_d;
         hwrite_s = w_pend_d ? w_pwrite_d : hwrite_d;
      end else if (w_sel_i) begin
         htrans_s = HTRANS_NONSEQ;
         haddr_s  = w_pend_i ? w_paddr_i  : haddr_i;
         hsize_s  = w_pend_i ? w_psize_i  : hsize_i;
         hwrite_s = w_pend_i ? w_pwrite_i : hwrite_i;
      end
   end

   // Keeps the slave address bus steady across idle cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_haddr_hold  <= '0;
         r_hsize_hold  <= '0;
         r_hwrite_hold <= 1'b0;
      end else if (w_sel_i || w_sel_d) begin
         r_haddr_hold  <= haddr_s;
         r_hsize_hold  <= hsize_s;
         r_hwrite_hold <= hwrite_s;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next data-phase owner plus data-phase steering.
   always_comb begin
      w_state_nxt = r_state;
      hwdata_s    = '0;
      hrdata_i    = '0;
      hrdata_d    = '0;
      hresp_i     = 1'b0;
      hresp_d     = 1'b0;
      if (hready_s) begin
         if (w_gnt_i) begin
            w_state_nxt = ST_DPH_I;
         end else if (w_gnt_d) begin
            w_state_nxt = ST_DPH_D;
         end else begin
            w_state_nxt = ST_IDLE;
         end
      end
      case (r_state)
         ST_DPH_I: begin
            hwdata_s = hwdata_i;
            hrdata_i = hrdata_s;
            hresp_i  = hresp_s;
         end
         ST_DPH_D: begin
            hwdata_s = hwdata_d;
            hrdata_d = hrdata_s;
            hresp_d  = hresp_s;
         end
         default: begin
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_ahb_lite_arb2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_ahb_lite_arb2                                          |
// | Purpose  : Directed self-checking bench for ahb_lite_arb2. The slave |
// |            return signals are driven straight from the stimulus.     |
// | Ports    : none                                                      |
// | Config   : URV_ARB_ROUND_ROBIN_EN changes the expected contest       |
// |            winners.                                                  |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_ahb_lite_arb2;
   import urv_ahb_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] haddr_i, haddr_d, haddr_s;
   logic [1:0]  htrans_i, htrans_d, htrans_s;
   logic [2:0]  hsize_i, hsize_d, hsize_s;
   logic        hwrite_i, hwrite_d, hwrite_s;
   logic [31:0] hwdata_i, hwdata_d, hwdata_s;
   logic [31:0] hrdata_i, hrdata_d, hrdata_s;
   logic        hready_i, hready_d, hready_s;
   logic        hresp_i, hresp_d, hresp_s;

   int          n_checks = 0;
   int          n_err    = 0;
   logic        d_wins;
   logic [31:0] a_i, a_d;

   always #5 clk = ~clk;

   ahb_lite_arb2 #(.AW(32), .DW(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .haddr_i  (haddr_i),
      .htrans_i (htrans_i),
      .hsize_i  (hsize_i),
      .hwrite_i (hwrite_i),
      .hwdata_i (hwdata_i),
      .hrdata_i (hrdata_i),
      .hready_i (hready_i),
      .hresp_i  (hresp_i),
      .haddr_d  (haddr_d),
      .htrans_d (htrans_d),
      .hsize_d  (hsize_d),
      .hwrite_d (hwrite_d),
      .hwdata_d (hwdata_d),
      .hrdata_d (hrdata_d),
      .hready_d (hready_d),
      .hresp_d  (hresp_d),
      .haddr_s  (haddr_s),
      .htrans_s (htrans_s),
      .hsize_s  (hsize_s),
      .hwrite_s (hwrite_s),
      .hwdata_s (hwdata_s),
      .hrdata_s (hrdata_s),
      .hready_s (hready_s),
      .hresp_s  (hresp_s)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drv_i(input logic ns, input logic [31:0] a, input logic w);
      htrans_i = ns ? HTRANS_NONSEQ : HTRANS_IDLE;
      haddr_i  = a;
      hwrite_i = w;
      hsize_i  = 3'd2;
   endtask

   task automatic drv_d(input logic ns, input logic [31:0] a, input logic w);
      htrans_d = ns ? HTRANS_NONSEQ : HTRANS_IDLE;
      haddr_d  = a;
      hwrite_d = w;
      hsize_d  = 3'd1;
   endtask

   task automatic slv(input logic rdy, input logic rsp, input logic [31:0] rd);
      hready_s = rdy;
      hresp_s  = rsp;
      hrdata_s = rd;
   endtask

   initial begin
      // ---------------- reset state, with D already requesting
      rst      = 1'b1;
      d_wins   = 1'b1;
      drv_i(1'b0, 32'h0, 1'b0);
      drv_d(1'b1, 32'h55, 1'b1);
      hwdata_i = 32'h0;
      hwdata_d = 32'h0;
      slv(1'b1, 1'b1, 32'hFFFF_FFFF);
      #1;
      chk("rst_htrans_s", htrans_s, HTRANS_IDLE);
      chk("rst_haddr_s",  haddr_s,  32'h0);
      chk("rst_hsize_s",  hsize_s,  3'd0);
      chk("rst_hwrite_s", hwrite_s, 1'b0);
      chk("rst_hwdata_s", hwdata_s, 32'h0);
      chk("rst_hready_i", hready_i, 1'b1);
      chk("rst_hready_d", hready_d, 1'b1);
      chk("rst_hresp_i",  hresp_i,  1'b0);
      chk("rst_hresp_d",  hresp_d,  1'b0);
      chk("rst_hrdata_i", hrdata_i, 32'h0);
      chk("rst_hrdata_d", hrdata_d, 32'h0);
      repeat (2) @(posedge clk);

      // ---------------- lone I read of 0x100
      @(negedge clk);
      rst = 1'b0;
      drv_d(1'b0, 32'h0, 1'b0);
      slv(1'b1, 1'b0, 32'h0);
      drv_i(1'b1, 32'h100, 1'b0);
      #1;
      chk("lone_htrans_s", htrans_s, HTRANS_NONSEQ);
      chk("lone_haddr_s",  haddr_s,  32'h100);
      chk("lone_hsize_s",  hsize_s,  3'd2);
      chk("lone_hwrite_s", hwrite_s, 1'b0);
      chk("lone_hready_d", hready_d, 1'b1);
      @(negedge clk);
      drv_i(1'b0, 32'h0, 1'b0);
      slv(1'b1, 1'b0, 32'hCAFE_0001);
      #1;
      chk("lone_hrdata_i", hrdata_i, 32'hCAFE_0001);
      chk("lone_hready_i", hready_i, 1'b1);
      chk("lone_hready_d2", hready_d, 1'b1);
      chk("lone_hrdata_d", hrdata_d, 32'h0);
      chk("lone_idle",     htrans_s, HTRANS_IDLE);
      chk("lone_hold",     haddr_s,  32'h100);

      // ---------------- simultaneous requests, four rounds
      for (int r = 0; r < 4; r++) begin
         a_d = 32'h300 + r * 8;
         a_i = 32'h400 + r * 8;
         @(negedge clk);
         drv_i(1'b1, a_i, 1'b0);
         drv_d(1'b1, a_d, 1'b1);
         slv(1'b1, 1'b0, 32'h0);
         #1;
         chk("arb_win_trans",  htrans_s, HTRANS_NONSEQ);
         chk("arb_win_addr",   haddr_s,  d_wins ? a_d : a_i);
         chk("arb_win_rdy_i",  hready_i, 1'b1);
         chk("arb_win_rdy_d",  hready_d, 1'b1);
         @(negedge clk);
         drv_i(1'b0, 32'h0, 1'b0);
         drv_d(1'b0, 32'h0, 1'b0);
         #1;
         chk("arb_lose_trans", htrans_s, HTRANS_NONSEQ);
         chk("arb_lose_addr",  haddr_s,  d_wins ? a_i : a_d);
         chk("arb_lose_size",  hsize_s,  d_wins ? 3'd2 : 3'd1);
         chk("arb_lose_rdy_i", hready_i, d_wins ? 1'b0 : 1'b1);
         chk("arb_lose_rdy_d", hready_d, d_wins ? 1'b1 : 1'b0);
         @(negedge clk);
         #1;
         chk("arb_end_trans",  htrans_s, HTRANS_IDLE);
         chk("arb_end_rdy_i",  hready_i, 1'b1);
         chk("arb_end_rdy_d",  hready_d, 1'b1);
`ifdef URV_ARB_ROUND_ROBIN_EN
         d_wins = !d_wins;
`endif
      end

      // ---------------- alternating requests, zero-wait slave
      @(negedge clk);
      drv_i(1'b1, 32'h120, 1'b0);
      #1;
      chk("alt_addr0", haddr_s, 32'h120);
      @(negedge clk);
      drv_i(1'b0, 32'h0, 1'b0);
      drv_d(1'b1, 32'h230, 1'b1);
      slv(1'b1, 1'b0, 32'h1200_0000);
      #1;
      chk("alt_addr1",    haddr_s,  32'h230);
      chk("alt_hrdata_i", hrdata_i, 32'h1200_0000);
      chk("alt_rdy_d1",   hready_d, 1'b1);
      @(negedge clk);
      drv_d(1'b0, 32'h0, 1'b0);
      drv_i(1'b1, 32'h124, 1'b0);
      hwdata_d = 32'h2300_0000;
      #1;
      chk("alt_addr2",    haddr_s,  32'h124);
      chk("alt_hwdata_s", hwdata_s, 32'h2300_0000);
      chk("alt_rdy_i2",   hready_i, 1'b1);
      @(negedge clk);
      drv_i(1'b0, 32'h0, 1'b0);
      slv(1'b1, 1'b0, 32'h1240_0000);
      #1;
      chk("alt_idle",     htrans_s, HTRANS_IDLE);
      chk("alt_hrdata3",  hrdata_i, 32'h1240_0000);

      // ---------------- D write with two wait states, I queued behind it
      @(negedge clk);
      drv_d(1'b1, 32'h200, 1'b1);
      slv(1'b1, 1'b0, 32'h0);
      #1;
      chk("ws_addr_d", haddr_s, 32'h200);
      @(negedge clk);
      drv_d(1'b0, 32'h0, 1'b0);
      hwdata_d = 32'hDEAD_BEEF;
      drv_i(1'b1, 32'h108, 1'b0);
      slv(1'b0, 1'b0, 32'h0);
      #1;
      chk("ws1_hwdata", hwdata_s, 32'hDEAD_BEEF);
      chk("ws1_rdy_d",  hready_d, 1'b0);
      chk("ws1_rdy_i",  hready_i, 1'b1);
      @(negedge clk);
      drv_i(1'b0, 32'h0, 1'b0);
      #1;
      chk("ws2_hwdata", hwdata_s, 32'hDEAD_BEEF);
      chk("ws2_rdy_d",  hready_d, 1'b0);
      chk("ws2_rdy_i",  hready_i, 1'b0);
      @(negedge clk);
      slv(1'b1, 1'b0, 32'h0);
      #1;
      chk("ws3_hwdata", hwdata_s, 32'hDEAD_BEEF);
      chk("ws3_rdy_d",  hready_d, 1'b1);
      chk("ws3_rdy_i",  hready_i, 1'b0);
      chk("ws3_trans",  htrans_s, HTRANS_NONSEQ);
      chk("ws3_addr",   haddr_s,  32'h108);
      @(negedge clk);
      slv(1'b1, 1'b0, 32'h0108_D00D);
      #1;
      chk("ws4_hrdata_i", hrdata_i, 32'h0108_D00D);
      chk("ws4_rdy_i",    hready_i, 1'b1);
      chk("ws4_hwdata",   hwdata_s, 32'h0);
      chk("ws4_idle",     htrans_s, HTRANS_IDLE);

      // ---------------- ERROR on an I fetch, D transfer behind it
      @(negedge clk);
      drv_i(1'b1, 32'h10C, 1'b0);
      #1;
      chk("err_addr_i", haddr_s, 32'h10C);
      @(negedge clk);
      drv_i(1'b0, 32'h0, 1'b0);
      drv_d(1'b1, 32'h210, 1'b1);
      slv(1'b0, 1'b1, 32'h0);
      #1;
      chk("err1_resp_i", hresp_i,  1'b1);
      chk("err1_rdy_i",  hready_i, 1'b0);
      chk("err1_resp_d", hresp_d,  1'b0);
      chk("err1_rdy_d",  hready_d, 1'b1);
      @(negedge clk);
      drv_d(1'b0, 32'h0, 1'b0);
      slv(1'b1, 1'b1, 32'h0);
      #1;
      chk("err2_resp_i", hresp_i,  1'b1);
      chk("err2_rdy_i",  hready_i, 1'b1);
      chk("err2_resp_d", hresp_d,  1'b0);
      chk("err2_rdy_d",  hready_d, 1'b0);
      chk("err2_addr",   haddr_s,  32'h210);
      chk("err2_write",  hwrite_s, 1'b1);
      @(negedge clk);
      slv(1'b1, 1'b0, 32'h0);
      hwdata_d = 32'h5A5A_5A5A;
      #1;
      chk("err3_resp_i", hresp_i,  1'b0);
      chk("err3_rdy_d",  hready_d, 1'b1);
      chk("err3_resp_d", hresp_d,  1'b0);
      chk("err3_hwdata", hwdata_s, 32'h5A5A_5A5A);

      // ---------------- reset pulse while D's buffer is full
      @(negedge clk);
      drv_i(1'b1, 32'h110, 1'b0);
      #1;
      chk("rp_addr_i", haddr_s, 32'h110);
      @(negedge clk);
      drv_i(1'b0, 32'h0, 1'b0);
      drv_d(1'b1, 32'h220, 1'b1);
      slv(1'b0, 1'b0, 32'h0);
      #1;
      chk("rp_rdy_d_accept", hready_d, 1'b1);
      @(negedge clk);
      drv_d(1'b0, 32'h0, 1'b0);
      #1;
      chk("rp_rdy_d_full", hready_d, 1'b0);
      rst = 1'b1;
      #1;
      chk("rp_in_trans",  htrans_s, HTRANS_IDLE);
      chk("rp_in_addr",   haddr_s,  32'h0);
      chk("rp_in_rdy_d",  hready_d, 1'b1);
      chk("rp_in_rdy_i",  hready_i, 1'b1);
      @(negedge clk);
      rst = 1'b0;
      slv(1'b1, 1'b0, 32'h0);
      #1;
      chk("rp_post_trans", htrans_s, HTRANS_IDLE);
      chk("rp_post_rdy_d", hready_d, 1'b1);
      chk("rp_post_rdy_i", hready_i, 1'b1);
      @(negedge clk);
      #1;
      chk("rp_post_trans2", htrans_s, HTRANS_IDLE);
      chk("rp_post_addr2",  haddr_s,  32'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
